// File: rtl/glitch_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// glitch_cmd_ctrl
//
// Byte-oriented command decoder sitting between a UART and a glitch engine.
// A frame is one opcode byte, optionally followed by a 4-byte little-endian
// payload:
//   0x01 SET_DELAY <4 bytes>  -> cfg_delay, reply 0xA5
//   0x02 SET_WIDTH <4 bytes>  -> cfg_width, reply 0xA5
//   0x03 ARM                  -> one-cycle arm pulse, reply 0xA5 on glitch_done
//   0x04 STATUS               -> reply {6'b0, overrun, armed_once}
//   0xFF CLEAR                -> zero cfg_delay, cfg_width, overrun, reply 0xA5
//   anything else             -> reply 0xEE
// Bytes received while a command is executing or replying are dropped and
// set a sticky overrun flag.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   rx_data[7:0] in   received byte, valid with rx_valid
//   rx_valid     in   one-cycle strobe per received byte
//   tx_data[7:0] out  reply byte (held from SEND until back in IDLE)
//   tx_en        out  one-cycle transmit request
//   tx_rdy       in   transmitter idle
//   cfg_delay    out  32-bit glitch delay register
//   cfg_width    out  32-bit glitch width register
//   arm          out  one-cycle glitch start strobe
//   glitch_done  in   one-cycle completion strobe from the glitch engine
//   busy         out  high whenever the controller is not IDLE
//
// Build option:
//   GLITCH_CMD_TIMEOUT_EN  when defined, a payload that stalls for
//                          TIMEOUT_CYCLES cycles between bytes is abandoned
//                          silently; otherwise PAYLOAD waits indefinitely.
// ---------------------------------------------------------------------------
module glitch_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_rdy,
    output logic [31:0] cfg_delay,
    output logic [31:0] cfg_width,
    output logic        arm,
    input  logic        glitch_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_EXEC,
        ST_WAIT_GLITCH,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    localparam logic [7:0] OP_SET_DELAY = 8'h01;
    localparam logic [7:0] OP_SET_WIDTH = 8'h02;
    localparam logic [7:0] OP_ARM       = 8'h03;
    localparam logic [7:0] OP_STATUS    = 8'h04;
    localparam logic [7:0] OP_CLEAR     = 8'hFF;
    localparam logic [7:0] REPLY_OK     = 8'hA5;
    localparam logic [7:0] REPLY_ERR    = 8'hEE;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    state_t      state_q;
    logic [7:0]  opcode_q;
    logic [31:0] payload_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] cfg_delay_q;
    logic [31:0] cfg_width_q;
    logic [7:0]  tx_data_q;
    logic        tx_en_q;
    logic        arm_q;
    logic        overrun_q;
    logic        armed_once_q;

    // Little-endian assembly: each new byte enters at the top and the word
    // shifts down, so the first byte ends up in bits 7:0 after four bytes.
    logic [31:0] payload_d;
    logic [7:0]  status_d;
    logic        drop_byte_d;

    assign payload_d   = {rx_data, payload_q[31:8]};
    assign status_d    = {6'b0, overrun_q, armed_once_q};
    assign drop_byte_d = rx_valid && (state_q inside {ST_EXEC, ST_WAIT_GLITCH,
                                                      ST_SEND, ST_WAIT_TX});

`ifdef GLITCH_CMD_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_q;
`else
    // No inter-byte timeout: a partial payload waits for its remaining bytes
    // until reset.
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            opcode_q     <= 8'h00;
            payload_q    <= 32'h0;
            byte_cnt_q   <= 2'd0;
            cfg_delay_q  <= 32'h0;
            cfg_width_q  <= 32'h0;
            tx_data_q    <= 8'h00;
            tx_en_q      <= 1'b0;
            arm_q        <= 1'b0;
            overrun_q    <= 1'b0;
            armed_once_q <= 1'b0;
`ifdef GLITCH_CMD_TIMEOUT_EN
            tmo_cnt_q    <= 32'h0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            tx_en_q <= 1'b0;
            arm_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        opcode_q   <= rx_data;
                        byte_cnt_q <= 2'd0;
`ifdef GLITCH_CMD_TIMEOUT_EN
                        tmo_cnt_q  <= 32'h0;
`endif
                        case (rx_data)
                            OP_SET_DELAY, OP_SET_WIDTH: state_q <= ST_PAYLOAD;
                            OP_ARM, OP_STATUS, OP_CLEAR: state_q <= ST_EXEC;
                            default: begin
                                tx_data_q <= REPLY_ERR;
                                state_q   <= ST_SEND;
                            end
                        endcase
                    end
                end

                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        payload_q  <= payload_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef GLITCH_CMD_TIMEOUT_EN
                        tmo_cnt_q  <= 32'h0;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= ST_EXEC;
                        end
                    end
`ifdef GLITCH_CMD_TIMEOUT_EN
                    // Abandon the frame without a reply; the config registers
                    // are only written in EXEC, so they stay untouched.
                    else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_cnt_q <= 32'h0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
`endif
                end

                ST_EXEC: begin
                    case (opcode_q)
                        OP_SET_DELAY: begin
                            cfg_delay_q <= payload_q;
                            tx_data_q   <= REPLY_OK;
                            state_q     <= ST_SEND;
                        end
                        OP_SET_WIDTH: begin
                            cfg_width_q <= payload_q;
                            tx_data_q   <= REPLY_OK;
                            state_q     <= ST_SEND;
                        end
                        OP_ARM: begin
                            arm_q   <= 1'b1;
                            state_q <= ST_WAIT_GLITCH;
                        end
                        OP_STATUS: begin
                            tx_data_q <= status_d;
                            state_q   <= ST_SEND;
                        end
                        OP_CLEAR: begin
                            cfg_delay_q <= 32'h0;
                            cfg_width_q <= 32'h0;
                            overrun_q   <= 1'b0;
                            tx_data_q   <= REPLY_OK;
                            state_q     <= ST_SEND;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end

                ST_WAIT_GLITCH: begin
                    if (glitch_done) begin
                        armed_once_q <= 1'b1;
                        tx_data_q    <= REPLY_OK;
                        state_q      <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (tx_rdy) begin
                        tx_en_q <= 1'b1;
                        state_q <= ST_WAIT_TX;
                    end
                end

                ST_WAIT_TX: begin
                    // Wait for the transmitter to accept the byte (go busy)
                    // before accepting the next frame.
                    if (!tx_rdy) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase

            // Placed after the case so a byte dropped during CLEAR still
            // leaves the overrun flag set.
            if (drop_byte_d) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign arm       = arm_q;
    assign cfg_delay = cfg_delay_q;
    assign cfg_width = cfg_width_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
